// File: rtl/key_repeat_array_if.sv
// Key conditioner bus: raw key pins in, debounced level and event pulses out.
// The conditioner itself sits on the slave modport; the pin/board side is master.
interface key_repeat_array_if #(
  parameter int CHANNELS = 4
);
  // Handshake: there is no valid/ready pair. key_in is sampled every cycle.
  // press and release_pulse are fire-and-forget strobes, high for exactly one
  // clk cycle, and the consumer must take them in that cycle (no backpressure).
  // level and repeating are plain registered levels.
  logic [CHANNELS-1:0]   key_in;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   press;
  logic [CHANNELS-1:0]   release_pulse; // 'release' is a reserved word in SV
  logic [CHANNELS-1:0]   repeating;
  logic [2*CHANNELS-1:0] fsm_state;     // per-channel FSM state, 2 bits each

  modport master (
    output key_in,
    input  level, press, release_pulse, repeating, fsm_state
  );

  modport slave (
    input  key_in,
    output level, press, release_pulse, repeating, fsm_state
  );
endinterface

// File: rtl/key_repeat_array.sv
// key_repeat_array: per-channel 2-FF synchroniser, counter debounce, press/
// release pulses and (optionally) press-and-hold auto-repeat.
// Optional feature macro: KEY_AUTOREPEAT_EN. Defined -> IDLE/DELAY/REPEAT FSM
// with hold delay and repeat period; undefined -> one press per debounced rise,
// repeating tied low, HOLD_CYC/REPEAT_CYC only range-checked.
module key_repeat_array #(
  parameter int CHANNELS     = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000
) (
  input logic              clk,
  input logic              reset_n,
  key_repeat_array_if.slave kif
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
  // Pin value of a released key; also the synchroniser reset value.
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

`ifdef KEY_AUTOREPEAT_EN
  localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;
`endif

  // Reject parameter values the timing below cannot honour.
  if (DEBOUNCE_CYC < 1 || HOLD_CYC < 2 || REPEAT_CYC < 2) begin : g_param_check
    $error("key_repeat_array: need DEBOUNCE_CYC>=1, HOLD_CYC>=2, REPEAT_CYC>=2");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          sync1, sync2;
    logic          pressed;
    logic [DW-1:0] deb_cnt;
    logic          level_r, level_q;
    logic          rise, fall;
    logic          press_r, release_r, repeating_r;
    logic [1:0]    state_dbg;

    // Normalise polarity after the synchroniser: 1 = pressed from here on.
    assign pressed = sync2 ^ IDLE_PIN;
    assign rise    = level_r & ~level_q;
    assign fall    = ~level_r & level_q;

    // Synchronise, debounce, and register the release strobe one cycle after the fall.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1     <= IDLE_PIN;
        sync2     <= IDLE_PIN;
        deb_cnt   <= '0;
        level_r   <= 1'b0;
        level_q   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        sync1     <= kif.key_in[g];
        sync2     <= sync1;
        level_q   <= level_r;
        release_r <= fall;
        if (pressed == level_r) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_cnt <= '0;
          level_r <= ~level_r;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    state_t        state;
    logic [TW-1:0] timer;

    // Hold/repeat FSM; a falling level always wins over a timer expiry.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state       <= S_IDLE;
        timer       <= '0;
        press_r     <= 1'b0;
        repeating_r <= 1'b0;
      end else begin
        press_r <= 1'b0;
        case (state)
          S_IDLE: begin
            timer       <= '0;
            repeating_r <= 1'b0;
            if (rise) begin
              press_r <= 1'b1;
              state   <= S_DELAY;
            end
          end
          S_DELAY: begin
            if (!level_r) begin
              state <= S_IDLE;
              timer <= '0;
            end else if (timer == HOLD_LAST) begin
              press_r     <= 1'b1;
              timer       <= '0;
              state       <= S_REPEAT;
              repeating_r <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_REPEAT: begin
            if (!level_r) begin
              state       <= S_IDLE;
              timer       <= '0;
              repeating_r <= 1'b0;
            end else if (timer == REP_LAST) begin
              press_r <= 1'b1;
              timer   <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state       <= S_IDLE;
            timer       <= '0;
            repeating_r <= 1'b0;
          end
        endcase
      end
    end

    assign state_dbg = state;
`else
    // Without auto-repeat a press is simply the registered debounced rise.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        press_r <= 1'b0;
      end else begin
        press_r <= rise;
      end
    end

    assign repeating_r = 1'b0;
    assign state_dbg   = 2'b00;
`endif

    assign kif.level[g]             = level_r;
    assign kif.press[g]             = press_r;
    assign kif.release_pulse[g]     = release_r;
    assign kif.repeating[g]         = repeating_r;
    assign kif.fsm_state[2*g +: 2]  = state_dbg;
  end

endmodule

// File: tb/tb_key_repeat_array.sv
// Bench for key_repeat_array (CHANNELS=2, ACTIVE_LOW=1, DEBOUNCE_CYC=4,
// HOLD_CYC=20, REPEAT_CYC=5). Expected press/release edge numbers are pushed
// per channel when a key is driven and popped when the DUT pulses; level and
// repeating are compared every cycle against windows derived from the same
// schedule. Build with or without KEY_AUTOREPEAT_EN.
module tb_key_repeat_array;
  localparam int CH   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int LAT  = 2 + DEB;  // pin change to level change, in edges

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int edge_n = 0;  // number of rising edges so far
  always @(posedge clk) edge_n <= edge_n + 1;

  key_repeat_array_if #(.CHANNELS(CH)) kif ();

  key_repeat_array #(
    .CHANNELS    (CH),
    .ACTIVE_LOW  (1),
    .DEBOUNCE_CYC(DEB),
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .kif    (kif.slave)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_press0_q[$];
  logic [31:0] exp_press1_q[$];
  logic [31:0] exp_rel0_q[$];
  logic [31:0] exp_rel1_q[$];
  int lvl_lo[CH] = '{1, 1};
  int lvl_hi[CH] = '{0, 0};
  int rep_lo[CH] = '{1, 1};
  int rep_hi[CH] = '{0, 0};
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void push_press(int ch, int e);
    if (ch == 0) exp_press0_q.push_back(32'(e));
    else         exp_press1_q.push_back(32'(e));
  endfunction

  function automatic void push_rel(int ch, int e);
    if (ch == 0) exp_rel0_q.push_back(32'(e));
    else         exp_rel1_q.push_back(32'(e));
  endfunction

  function automatic logic [31:0] pop_press(int ch);
    logic [31:0] v;
    v = 32'hFFFF_FFFF;
    if (ch == 0) begin
      if (exp_press0_q.size() > 0) v = exp_press0_q.pop_front();
    end else begin
      if (exp_press1_q.size() > 0) v = exp_press1_q.pop_front();
    end
    return v;
  endfunction

  function automatic logic [31:0] pop_rel(int ch);
    logic [31:0] v;
    v = 32'hFFFF_FFFF;
    if (ch == 0) begin
      if (exp_rel0_q.size() > 0) v = exp_rel0_q.pop_front();
    end else begin
      if (exp_rel1_q.size() > 0) v = exp_rel1_q.pop_front();
    end
    return v;
  endfunction

  // Key goes to its pressed pin value after edge k. Level is high for edges
  // [k+LAT, lvl_end]; presses are allowed up to press_end; rel_edge=0 means
  // the run is cut by reset and no release pulse is due.
  function automatic void schedule(int ch, int k, int lvl_end, int press_end, int rel_edge);
    int t0;
    t0 = k + LAT + 1;
    lvl_lo[ch] = k + LAT;
    lvl_hi[ch] = lvl_end;
    if (t0 <= press_end) push_press(ch, t0);
`ifdef KEY_AUTOREPEAT_EN
    rep_lo[ch] = t0 + HOLD;
    rep_hi[ch] = press_end;
    for (int p = t0 + HOLD; p <= press_end; p += REP) push_press(ch, p);
`endif
    if (rel_edge > 0) push_rel(ch, rel_edge);
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      logic exp_lvl, exp_rep;
      logic [31:0] want, got;
      exp_lvl = (edge_n >= lvl_lo[c]) && (edge_n <= lvl_hi[c]);
      exp_rep = (edge_n >= rep_lo[c]) && (edge_n <= rep_hi[c]);
      got = 32'(edge_n);
      n_tests++;
      assert (kif.level[c] === exp_lvl) else begin
        n_fail++;
        $error("FAIL level ch%0d edge %0d: observed %b expected %b", c, edge_n, kif.level[c], exp_lvl);
      end
      n_tests++;
      assert (kif.repeating[c] === exp_rep) else begin
        n_fail++;
        $error("FAIL repeating ch%0d edge %0d: observed %b expected %b", c, edge_n, kif.repeating[c], exp_rep);
      end
      if (kif.press[c] !== 1'b0) begin
        want = pop_press(c);
        n_tests++;
        assert (got === want) else begin
          n_fail++;
          $error("FAIL press_edge ch%0d: observed pulse at edge %0d expected edge %0d", c, got, want);
        end
      end
      if (kif.release_pulse[c] !== 1'b0) begin
        want = pop_rel(c);
        n_tests++;
        assert (got === want) else begin
          n_fail++;
          $error("FAIL release_edge ch%0d: observed pulse at edge %0d expected edge %0d", c, got, want);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance n falling edges, then step just past so drives never race the monitor.
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_hold(input int ch, input int hold);
    int k;
    k = edge_n;
    schedule(ch, k, k + hold + LAT - 1, k + hold + LAT, k + hold + LAT + 1);
    kif.key_in[ch] = 1'b0;
    wait_cycles(hold);
    kif.key_in[ch] = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_tests++;
    assert (kif.level === '0) else begin
      n_fail++; $error("FAIL %s_level: observed %b expected 00", tag, kif.level);
    end
    n_tests++;
    assert (kif.press === '0) else begin
      n_fail++; $error("FAIL %s_press: observed %b expected 00", tag, kif.press);
    end
    n_tests++;
    assert (kif.release_pulse === '0) else begin
      n_fail++; $error("FAIL %s_release: observed %b expected 00", tag, kif.release_pulse);
    end
    n_tests++;
    assert (kif.repeating === '0) else begin
      n_fail++; $error("FAIL %s_repeating: observed %b expected 00", tag, kif.repeating);
    end
  endtask

  task automatic check_drained(input string tag);
    n_tests++;
    assert (exp_press0_q.size() == 0 && exp_press1_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_missing_press: observed %0d/%0d pending expected 0/0", tag, exp_press0_q.size(), exp_press1_q.size());
    end
    n_tests++;
    assert (exp_rel0_q.size() == 0 && exp_rel1_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_missing_release: observed %0d/%0d pending expected 0/0", tag, exp_rel0_q.size(), exp_rel1_q.size());
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, k1, d;
    reset_n    = 1'b0;
    kif.key_in = '1;
    wait_cycles(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    wait_cycles(5);

    // 1: glitch of DEB-1 cycles never reaches level.
    kif.key_in[0] = 1'b0;
    wait_cycles(DEB - 1);
    kif.key_in[0] = 1'b1;
    wait_cycles(15);
    check_drained("glitch");

    // 2: short press, single press pulse, release after LAT+1.
    press_hold(0, 10);
    wait_cycles(15);
    check_drained("short");

    // 3: long hold, repeat train (single press without auto-repeat).
    press_hold(0, 60);
    wait_cycles(15);
    check_drained("long");

    // 4: release inside the hold delay, then a fresh press restarts the delay.
    press_hold(0, 16);
    wait_cycles(10);
    press_hold(0, 30);
    wait_cycles(15);
    check_drained("redelay");

    // 5: both channels offset by 3, reset while held, fresh press afterwards.
    k = edge_n;
    schedule(0, k, k + 30, k + 30, 0);
    kif.key_in[0] = 1'b0;
    wait_cycles(3);
    k1 = edge_n;
    schedule(1, k1, k + 30, k + 30, 0);
    kif.key_in[1] = 1'b0;
    wait_cycles(27);
    reset_n = 1'b0;
    wait_cycles(1);
    check_outputs_zero("midreset");
    check_drained("pre_reset");
    wait_cycles(2);
    reset_n = 1'b1;
    d = edge_n;
    schedule(0, d, d + 15 + LAT - 1, d + 15 + LAT, d + 15 + LAT + 1);
    schedule(1, d, d + 15 + LAT - 1, d + 15 + LAT, d + 15 + LAT + 1);
    wait_cycles(15);
    kif.key_in = '1;
    wait_cycles(15);
    check_drained("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
